// File: rtl/data_break_ctrl.sv
// data_break_ctrl: data-break (DMA) front end for the CPU sequencer.
// Arbitrates cycle-steal requests from NCHAN devices, raises data_break to the
// sequencer, follows the DB0/DB1/DB2 states, drives the memory bus for one word
// per break and pulses dev_ack to the winning channel.
// Optional build macro DATA_BREAK_RR_EN: round-robin arbitration instead of
// fixed priority (channel 0 highest).
// Address/data buses are [N:0] with the MSB holding PDP-8 bit 0.
module data_break_ctrl #(
  parameter int         NCHAN  = 2,
  parameter logic [4:0] ST_DB0 = 5'd16,
  parameter logic [4:0] ST_DB1 = 5'd17,
  parameter logic [4:0] ST_DB2 = 5'd18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            state,
  input  logic                  break_in_prog,
  input  logic [NCHAN-1:0]      dev_req,
  input  logic [NCHAN-1:0]      dev_to_disk,
  input  logic [NCHAN*15-1:0]   dev_addr,
  input  logic [NCHAN*12-1:0]   dev_wdata,
  input  logic [11:0]           mem_rdata,
  output logic                  data_break,
  output logic                  to_disk,
  output logic [14:0]           mem_addr,
  output logic [11:0]           mem_wdata,
  output logic                  mem_we,
  output logic [NCHAN-1:0]      dev_ack,
  output logic [11:0]           dev_rdata
);

  localparam int GW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    XFER = 2'd2,
    ACK  = 2'd3
  } fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            data_break_q, data_break_d;
  logic            to_disk_q, to_disk_d;
  logic [14:0]     mem_addr_q, mem_addr_d;
  logic [11:0]     mem_wdata_q, mem_wdata_d;
  logic [11:0]     dev_rdata_q, dev_rdata_d;

  logic [GW-1:0]   win;
  logic            any_req;
  logic            in_db_seq;
  logic [14:0]     addr_arr  [NCHAN];
  logic [11:0]     wdata_arr [NCHAN];

  // Debug observation point: break flag dropped while a transfer is in flight.
  // It has no functional effect and is kept only as a hook for simulation checks.
  logic            unused_bip_warn;
  assign unused_bip_warn = (fsm_q == XFER) & ~break_in_prog;

  assign any_req   = |dev_req;
  assign in_db_seq = (state == ST_DB0) || (state == ST_DB1) || (state == ST_DB2);

  // Split the flat per-channel address and data buses into per-channel words.
  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      addr_arr[i]  = dev_addr[15*i +: 15];
      wdata_arr[i] = dev_wdata[12*i +: 12];
    end
  end

`ifdef DATA_BREAK_RR_EN
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   idx_g;
  logic            found;
  int              idx;

  // Round-robin search: first requester at or after the pointer wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    idx_g = '0;
    for (int k = 0; k < NCHAN; k++) begin
      idx   = (int'(rr_q) + k) % NCHAN;
      idx_g = GW'(idx);
      if (!found && dev_req[idx_g]) begin
        win   = idx_g;
        found = 1'b1;
      end
    end
  end

  // Pointer moves just past the channel that completed its break.
  always_comb begin
    rr_d = rr_q;
    if (fsm_q == ACK) begin
      rr_d = (grant_q == GW'(NCHAN - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority: lowest-numbered requesting channel wins.
  always_comb begin
    win = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (dev_req[i]) begin
        win = GW'(i);
      end
    end
  end
`endif

  // Next-state logic: latch a winner in IDLE, wait for DB0, move the word, ack.
  always_comb begin
    fsm_d        = fsm_q;
    grant_d      = grant_q;
    data_break_d = data_break_q;
    to_disk_d    = to_disk_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    dev_rdata_d  = dev_rdata_q;

    unique case (fsm_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = win;
          to_disk_d    = dev_to_disk[win];
          mem_addr_d   = addr_arr[win];
          mem_wdata_d  = wdata_arr[win];
          data_break_d = 1'b1;
          fsm_d        = PEND;
        end
      end
      PEND: begin
        // The sequencer may sit halted for any length of time before DB0.
        if (state == ST_DB0) begin
          data_break_d = 1'b0;
          fsm_d        = XFER;
        end
      end
      XFER: begin
        if (state == ST_DB2) begin
          if (to_disk_q) begin
            dev_rdata_d = mem_rdata;
          end
          fsm_d = ACK;
        end else if (!in_db_seq) begin
          // Sequencer left the break sequence: drop the transfer, no ack,
          // and let the still-pending request be arbitrated again.
          to_disk_d   = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          fsm_d       = IDLE;
        end
      end
      ACK: begin
        to_disk_d   = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        fsm_d       = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any break in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= IDLE;
      grant_q      <= '0;
      data_break_q <= 1'b0;
      to_disk_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      dev_rdata_q  <= '0;
    end else begin
      fsm_q        <= fsm_d;
      grant_q      <= grant_d;
      data_break_q <= data_break_d;
      to_disk_q    <= to_disk_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      dev_rdata_q  <= dev_rdata_d;
    end
  end

  assign data_break = data_break_q;
  assign to_disk    = to_disk_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign dev_rdata  = dev_rdata_q;
  assign mem_we     = (fsm_q == XFER) && (state == ST_DB1) && !to_disk_q;
  assign dev_ack    = (fsm_q == ACK) ? (NCHAN'(1) << grant_q) : '0;

endmodule
